// File: rtl/core_types_pkg.sv
// core_types_pkg -- shared core types used by the instruction queue.
//   IQ_DEPTH      default instruction-queue entry count (power of 2, >= 2)
//   LOG_IQ_DEPTH  pointer width for the default depth
//   word_t        32-bit instruction word
//   pc_t          14-bit word-granular program counter
//   iq_entry_t    one queue entry: {instr, PC, nPC}
package core_types_pkg;

  localparam int IQ_DEPTH     = 4;
  localparam int LOG_IQ_DEPTH = $clog2(IQ_DEPTH);

  typedef logic [31:0] word_t;
  typedef logic [13:0] pc_t;

  typedef struct packed {
    word_t instr;
    pc_t   PC;
    pc_t   nPC;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue.sv
// instr_queue -- circular FIFO between fetch and dispatch.
//
// Optional feature: define INSTR_QUEUE_BYPASS_EN to let a fetched
// instruction reach dispatch in the same cycle when the queue is empty.
// Without it, fetch-to-dispatch latency is at least one cycle.
//
// Ports
//   CLK                          clock, rising edge
//   nRST                         asynchronous active-low reset
//   from_fetch_ivalid            fetched instruction valid this cycle
//   from_fetch_instr  [31:0]     fetched instruction
//   from_fetch_PC     [13:0]     word-granular PC of the instruction
//   from_fetch_nPC    [13:0]     predicted next PC
//   from_pipeline_take_resolved  mispredict flush; empties the queue
//   from_dispatch_ready          dispatch accepts the head this cycle
//   to_dispatch_valid            head valid
//   to_dispatch_instr [31:0]     head instruction
//   to_dispatch_PC    [13:0]     head PC
//   to_dispatch_nPC   [13:0]     head predicted next PC
//   to_core_control_full         queue full (from registered count only)
//   DUT_error                    registered: fetch pushed into a full queue
module instr_queue #(
  parameter int IQ_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        from_fetch_ivalid,
  input  logic [31:0] from_fetch_instr,
  input  logic [13:0] from_fetch_PC,
  input  logic [13:0] from_fetch_nPC,
  input  logic        from_pipeline_take_resolved,
  input  logic        from_dispatch_ready,
  output logic        to_dispatch_valid,
  output logic [31:0] to_dispatch_instr,
  output logic [13:0] to_dispatch_PC,
  output logic [13:0] to_dispatch_nPC,
  output logic        to_core_control_full,
  output logic        DUT_error
);
  import core_types_pkg::iq_entry_t;

  localparam int LOG_IQ_DEPTH = $clog2(IQ_DEPTH);
  localparam logic [LOG_IQ_DEPTH:0] FULL_CNT = (LOG_IQ_DEPTH + 1)'(IQ_DEPTH);

  iq_entry_t                 r_mem [IQ_DEPTH];
  logic [LOG_IQ_DEPTH-1:0]   r_head, r_tail;
  logic [LOG_IQ_DEPTH:0]     r_count;
  logic                      r_error;

  logic [LOG_IQ_DEPTH-1:0]   w_head_n, w_tail_n;
  logic [LOG_IQ_DEPTH:0]     w_count_n;
  logic                      w_error_n;
  logic                      w_full, w_byp, w_enq, w_deq;
  iq_entry_t                 w_wr_entry, w_head_entry;

  assign w_full       = (r_count == FULL_CNT);
  assign w_wr_entry   = '{instr: from_fetch_instr, PC: from_fetch_PC, nPC: from_fetch_nPC};
  assign w_head_entry = r_mem[r_head];

`ifdef INSTR_QUEUE_BYPASS_EN
  // Empty queue: present the fetched instruction directly. nRST gates it so
  // dispatch never sees a valid while the core is held in reset.
  assign w_byp = nRST & (r_count == '0) & from_fetch_ivalid & ~from_pipeline_take_resolved;
`else
  assign w_byp = 1'b0;
`endif

  assign to_dispatch_valid    = ((r_count != '0) | w_byp) & ~from_pipeline_take_resolved;
  assign to_dispatch_instr    = w_byp ? from_fetch_instr : w_head_entry.instr;
  assign to_dispatch_PC       = w_byp ? from_fetch_PC    : w_head_entry.PC;
  assign to_dispatch_nPC      = w_byp ? from_fetch_nPC   : w_head_entry.nPC;
  assign to_core_control_full = w_full;
  assign DUT_error            = r_error;

  // A bypassed instruction consumed by dispatch is never written; a stored
  // head is dequeued only when it is what dispatch actually saw.
  assign w_enq = from_fetch_ivalid & ~w_full & ~from_pipeline_take_resolved
               & ~(w_byp & from_dispatch_ready);
  assign w_deq = to_dispatch_valid & from_dispatch_ready & ~w_byp;

  // Pointer / count next state
  always_comb begin
    w_head_n  = r_head;
    w_tail_n  = r_tail;
    w_count_n = r_count;
    if (from_pipeline_take_resolved) begin
      w_head_n  = '0;
      w_tail_n  = '0;
      w_count_n = '0;
    end else begin
      if (w_enq) w_tail_n = r_tail + 1'b1;
      if (w_deq) w_head_n = r_head + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   w_count_n = r_count + 1'b1;
        2'b01:   w_count_n = r_count - 1'b1;
        default: w_count_n = r_count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_n;
      r_tail  <= w_tail_n;
      r_count <= w_count_n;
    end
  end

  // Entry storage
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < IQ_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_enq) begin
      r_mem[r_tail] <= w_wr_entry;
    end
  end

  // Error flag: a fetch arriving while full (and not flushed) is dropped.
  always_comb begin
    w_error_n = from_fetch_ivalid & w_full & ~from_pipeline_take_resolved;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_error <= 1'b0;
    else       r_error <= w_error_n;
  end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue -- directed, table-driven bench for instr_queue (IQ_DEPTH=4).
// Inputs are driven on the falling edge; outputs are compared 1 time unit
// later, i.e. the combinational view of the state registered at the
// previous rising edge plus the current inputs.
module tb_instr_queue;

`ifdef INSTR_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iv, fl, rdy;
  logic [31:0] instr;
  logic [13:0] pc, npc;
  logic        vld, full, err;
  logic [31:0] o_instr;
  logic [13:0] o_pc, o_npc;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  instr_queue #(.IQ_DEPTH(4)) dut (
    .CLK                         (CLK),
    .nRST                        (nRST),
    .from_fetch_ivalid           (iv),
    .from_fetch_instr            (instr),
    .from_fetch_PC               (pc),
    .from_fetch_nPC              (npc),
    .from_pipeline_take_resolved (fl),
    .from_dispatch_ready         (rdy),
    .to_dispatch_valid           (vld),
    .to_dispatch_instr           (o_instr),
    .to_dispatch_PC              (o_pc),
    .to_dispatch_nPC             (o_npc),
    .to_core_control_full        (full),
    .DUT_error                   (err)
  );

  typedef struct {
    logic        iv;
    logic [31:0] instr;
    logic [13:0] pc;
    logic        fl;
    logic        rdy;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [13:0] e_pc;
    logic        e_full;
    logic        e_err;
    int          e_cnt;
  } vec_t;

  vec_t tv[$];

  function automatic logic [31:0] ins(input logic [13:0] p);
    return 32'hA000_0000 | {18'h0, p};
  endfunction

  function automatic vec_t mk(input logic i_iv, input logic [31:0] i_in, input logic [13:0] i_pc,
                              input logic i_fl, input logic i_rdy, input logic e_v,
                              input logic [31:0] e_i, input logic [13:0] e_p,
                              input logic e_f, input logic e_e, input int e_c);
    vec_t v;
    v.iv = i_iv; v.instr = i_in; v.pc = i_pc; v.fl = i_fl; v.rdy = i_rdy;
    v.e_vld = e_v; v.e_instr = e_i; v.e_pc = e_p; v.e_full = e_f; v.e_err = e_e; v.e_cnt = e_c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    @(negedge CLK);
    iv = v.iv; instr = v.instr; pc = v.pc; npc = v.pc + 14'd1; fl = v.fl; rdy = v.rdy;
    #1;
    n_vec++;
    chk({nm, ".valid"}, {31'b0, vld},  {31'b0, v.e_vld});
    chk({nm, ".full"},  {31'b0, full}, {31'b0, v.e_full});
    chk({nm, ".err"},   {31'b0, err},  {31'b0, v.e_err});
    chk({nm, ".count"}, 32'(dut.r_count), 32'(v.e_cnt));
    if (v.e_vld) begin
      chk({nm, ".instr"}, o_instr, v.e_instr);
      chk({nm, ".PC"},    {18'b0, o_pc},  {18'b0, v.e_pc});
      chk({nm, ".nPC"},   {18'b0, o_npc}, {18'b0, v.e_pc + 14'd1});
    end
  endtask

  initial begin
    vec_t v;
    nRST = 1'b0; iv = 1'b0; fl = 1'b0; rdy = 1'b0; instr = '0; pc = '0; npc = '0;

    // Reset state
    #1;
    n_vec++;
    chk("rst.valid", {31'b0, vld},  32'd0);
    chk("rst.full",  {31'b0, full}, 32'd0);
    chk("rst.err",   {31'b0, err},  32'd0);
    chk("rst.count", 32'(dut.r_count), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Fill, overflow, full-dequeue, flush, enq+deq at count 3 and 1.
    tv.push_back(mk(1, 32'h8C010004, 14'h10, 0, 0, BYP, 32'h8C010004, 14'h10, 0, 0, 0));
    tv.push_back(mk(1, ins(14'h11), 14'h11, 0, 0, 1, 32'h8C010004, 14'h10, 0, 0, 1));
    tv.push_back(mk(1, ins(14'h12), 14'h12, 0, 0, 1, 32'h8C010004, 14'h10, 0, 0, 2));
    tv.push_back(mk(1, ins(14'h13), 14'h13, 0, 0, 1, 32'h8C010004, 14'h10, 0, 0, 3));
    tv.push_back(mk(1, ins(14'h14), 14'h14, 0, 0, 1, 32'h8C010004, 14'h10, 1, 0, 4));
    tv.push_back(mk(0, 32'h0,       14'h0,  0, 0, 1, 32'h8C010004, 14'h10, 1, 1, 4));
    tv.push_back(mk(1, ins(14'h15), 14'h15, 0, 1, 1, 32'h8C010004, 14'h10, 1, 0, 4));
    tv.push_back(mk(0, 32'h0,       14'h0,  0, 0, 1, ins(14'h11),  14'h11, 0, 1, 3));
    tv.push_back(mk(0, 32'h0,       14'h0,  0, 1, 1, ins(14'h11),  14'h11, 0, 0, 3));
    tv.push_back(mk(1, ins(14'h30), 14'h30, 1, 1, 0, 32'h0,        14'h0,  0, 0, 2));
    tv.push_back(mk(0, 32'h0,       14'h0,  0, 0, 0, 32'h0,        14'h0,  0, 0, 0));
    tv.push_back(mk(1, ins(14'h40), 14'h40, 0, 0, BYP, ins(14'h40), 14'h40, 0, 0, 0));
    tv.push_back(mk(1, ins(14'h41), 14'h41, 0, 0, 1, ins(14'h40),  14'h40, 0, 0, 1));
    tv.push_back(mk(1, ins(14'h42), 14'h42, 0, 0, 1, ins(14'h40),  14'h40, 0, 0, 2));
    tv.push_back(mk(1, ins(14'h43), 14'h43, 0, 1, 1, ins(14'h40),  14'h40, 0, 0, 3));
    tv.push_back(mk(0, 32'h0,       14'h0,  0, 0, 1, ins(14'h41),  14'h41, 0, 0, 3));
    tv.push_back(mk(0, 32'h0,       14'h0,  0, 1, 1, ins(14'h41),  14'h41, 0, 0, 3));
    tv.push_back(mk(0, 32'h0,       14'h0,  0, 1, 1, ins(14'h42),  14'h42, 0, 0, 2));
    tv.push_back(mk(1, ins(14'h44), 14'h44, 0, 1, 1, ins(14'h43),  14'h43, 0, 0, 1));
    tv.push_back(mk(0, 32'h0,       14'h0,  0, 1, 1, ins(14'h44),  14'h44, 0, 0, 1));
    tv.push_back(mk(0, 32'h0,       14'h0,  0, 0, 0, 32'h0,        14'h0,  0, 0, 0));

    foreach (tv[i]) step(tv[i], $sformatf("v%0d", i));

    // Stream PC 0..9 with enqueue and dequeue every cycle; pointers wrap.
    for (int k = 0; k <= 10; k++) begin
      logic [13:0] kp;
      kp = 14'(k);
      if (BYP)
        v = mk(k < 10, ins(kp), kp, 0, 1, k < 10, ins(kp), kp, 0, 0, 0);
      else if (k == 0)
        v = mk(1, ins(kp), kp, 0, 1, 0, 32'h0, 14'h0, 0, 0, 0);
      else
        v = mk(k < 10, ins(kp), kp, 0, 1, 1, ins(kp - 14'd1), kp - 14'd1, 0, 0, 1);
      step(v, $sformatf("s%0d", k));
    end
    step(mk(0, 32'h0, 14'h0, 0, 0, 0, 32'h0, 14'h0, 0, 0, 0), "s_end");

`ifdef INSTR_QUEUE_BYPASS_EN
    // Empty queue, ready=1: same-cycle bypass, nothing stored.
    step(mk(1, ins(14'h20), 14'h20, 0, 1, 1, ins(14'h20), 14'h20, 0, 0, 0), "byp0");
    step(mk(0, 32'h0, 14'h0, 0, 0, 0, 32'h0, 14'h0, 0, 0, 0), "byp1");
`endif

    // Reset asserted mid-operation wins over a pending enqueue.
    step(mk(1, ins(14'h50), 14'h50, 0, 0, BYP, ins(14'h50), 14'h50, 0, 0, 0), "r0");
    step(mk(1, ins(14'h51), 14'h51, 0, 0, 1, ins(14'h50), 14'h50, 0, 0, 1), "r1");
    @(negedge CLK);
    iv = 1'b1; instr = ins(14'h52); pc = 14'h52; npc = 14'h53; rdy = 1'b1;
    nRST = 1'b0;
    #1;
    n_vec++;
    chk("rmid.valid", {31'b0, vld},  32'd0);
    chk("rmid.count", 32'(dut.r_count), 32'd0);
    chk("rmid.full",  {31'b0, full}, 32'd0);
    @(negedge CLK);
    #1;
    n_vec++;
    chk("rmid2.count", 32'(dut.r_count), 32'd0);
    chk("rmid2.err",   {31'b0, err},  32'd0);
    iv = 1'b0; rdy = 1'b0;
    nRST = 1'b1;
    step(mk(0, 32'h0, 14'h0, 0, 0, 0, 32'h0, 14'h0, 0, 0, 0), "rpost");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
